// File: rtl/id_ex_stage_if.sv
// Decode-to-Execute bundle: decoded instruction, pipeline control, forward
// sources, and the operand/control fields presented to Execute.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [1:0]        id_alu_op;
  logic              id_src1_sel;
  logic              id_src2_sel;
  logic              id_reg_we;
  logic              id_mem_we;
  logic              stall;
  logic              flush;
  logic              mem_fwd_we;
  logic [REG_AW-1:0] mem_fwd_rd;
  logic [DATA_W-1:0] mem_fwd_data;
  logic              wb_fwd_we;
  logic [REG_AW-1:0] wb_fwd_rd;
  logic [DATA_W-1:0] wb_fwd_data;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [1:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_we;
  logic              ex_mem_we;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_src1_sel, id_src2_sel, id_reg_we, id_mem_we, stall, flush,
           mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
    input  ex_valid, ex_pc, alu_src1, alu_src2, ex_alu_op, ex_store_data,
           ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_we
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_src1_sel, id_src2_sel, id_reg_we, id_mem_we, stall, flush,
           mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
    output ex_valid, ex_pc, alu_src1, alu_src2, ex_alu_op, ex_store_data,
           ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_we
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, MEM/WB operand forwarding and
// final ALU operand selection for the Execute stage.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic     clk,
  input logic     rst,
  id_ex_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [1:0]        alu_op;
    logic              src1_sel;
    logic              src2_sel;
    logic              reg_we;
    logic              mem_we;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;

  logic [REG_AW-1:0] src_addr [2];
  logic [DATA_W-1:0] src_data [2];
  logic [DATA_W-1:0] fwd_data [2];
  logic              mem_hit  [2];
  logic              wb_hit   [2];

  assign src_addr[0] = stage_q.rs1;
  assign src_addr[1] = stage_q.rs2;
  assign src_data[0] = stage_q.rs1_data;
  assign src_data[1] = stage_q.rs2_data;

  // Index 0 is rs1, index 1 is rs2; MEM is younger so it beats WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign mem_hit[gi]  = bus.mem_fwd_we && (bus.mem_fwd_rd == src_addr[gi]) &&
                          (src_addr[gi] != '0);
    assign wb_hit[gi]   = bus.wb_fwd_we && (bus.wb_fwd_rd == src_addr[gi]) &&
                          (src_addr[gi] != '0);
    assign fwd_data[gi] = mem_hit[gi] ? bus.mem_fwd_data :
                          wb_hit[gi]  ? bus.wb_fwd_data  : src_data[gi];
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = '0;
    end else if (bus.stall) begin
      // A retiring WB result would vanish while we wait, so absorb it now.
      if (wb_hit[0]) stage_d.rs1_data = bus.wb_fwd_data;
      if (wb_hit[1]) stage_d.rs2_data = bus.wb_fwd_data;
    end else begin
      stage_d.valid    = bus.id_valid;
      stage_d.pc       = bus.id_pc;
      stage_d.rs1_data = bus.id_rs1_data;
      stage_d.rs2_data = bus.id_rs2_data;
      stage_d.imm      = bus.id_imm;
      stage_d.rs1      = bus.id_rs1;
      stage_d.rs2      = bus.id_rs2;
      stage_d.rd       = bus.id_rd;
      stage_d.alu_op   = bus.id_alu_op;
      stage_d.src1_sel = bus.id_src1_sel;
      stage_d.src2_sel = bus.id_src2_sel;
      stage_d.reg_we   = bus.id_reg_we & bus.id_valid;
      stage_d.mem_we   = bus.id_mem_we & bus.id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_pc         = stage_q.pc;
  assign bus.alu_src1      = stage_q.src1_sel ? stage_q.pc  : fwd_data[0];
  assign bus.alu_src2      = stage_q.src2_sel ? stage_q.imm : fwd_data[1];
  assign bus.ex_alu_op     = stage_q.alu_op;
  assign bus.ex_store_data = fwd_data[1];
  assign bus.ex_rs1        = stage_q.rs1;
  assign bus.ex_rs2        = stage_q.rs2;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_reg_we     = stage_q.reg_we;
  assign bus.ex_mem_we     = stage_q.mem_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_id_ex_stage;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(32), .REG_AW(5)) ifc ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Instruction currently held in Execute, as the model sees it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] imm;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic        s1;
    logic        s2;
    logic        rwe;
    logic        mwe;
  } mdl_t;

  mdl_t m = '0;

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
    if (r == 5'd0) return d;
    if (ifc.mem_fwd_we && ifc.mem_fwd_rd == r) return ifc.mem_fwd_data;
    if (ifc.wb_fwd_we && ifc.wb_fwd_rd == r) return ifc.wb_fwd_data;
    return d;
  endfunction

  function automatic logic [147:0] exp_outs();
    logic [31:0] a = operand(m.r1, m.r1d);
    logic [31:0] b = operand(m.r2, m.r2d);
    return {m.valid, m.pc, (m.s1 ? m.pc : a), (m.s2 ? m.imm : b), m.op, b,
            m.r1, m.r2, m.rd, m.rwe, m.mwe};
  endfunction

  function automatic logic [147:0] act_outs();
    return {ifc.ex_valid, ifc.ex_pc, ifc.alu_src1, ifc.alu_src2, ifc.ex_alu_op,
            ifc.ex_store_data, ifc.ex_rs1, ifc.ex_rs2, ifc.ex_rd,
            ifc.ex_reg_we, ifc.ex_mem_we};
  endfunction

  function automatic mdl_t model_next();
    mdl_t n = m;
    if (ifc.flush) begin
      n = '0;
    end else if (ifc.stall) begin
      if (ifc.wb_fwd_we && ifc.wb_fwd_rd != 0 && ifc.wb_fwd_rd == m.r1) n.r1d = ifc.wb_fwd_data;
      if (ifc.wb_fwd_we && ifc.wb_fwd_rd != 0 && ifc.wb_fwd_rd == m.r2) n.r2d = ifc.wb_fwd_data;
    end else begin
      n = '{valid: ifc.id_valid, pc: ifc.id_pc, r1d: ifc.id_rs1_data, r2d: ifc.id_rs2_data,
            imm: ifc.id_imm, r1: ifc.id_rs1, r2: ifc.id_rs2, rd: ifc.id_rd,
            op: ifc.id_alu_op, s1: ifc.id_src1_sel, s2: ifc.id_src2_sel,
            rwe: ifc.id_reg_we && ifc.id_valid, mwe: ifc.id_mem_we && ifc.id_valid};
    end
    return n;
  endfunction

  task automatic drive_idle();
    ifc.id_valid = 0; ifc.id_pc = 0; ifc.id_rs1_data = 0; ifc.id_rs2_data = 0;
    ifc.id_imm = 0; ifc.id_rs1 = 0; ifc.id_rs2 = 0; ifc.id_rd = 0;
    ifc.id_alu_op = 0; ifc.id_src1_sel = 0; ifc.id_src2_sel = 0;
    ifc.id_reg_we = 0; ifc.id_mem_we = 0; ifc.stall = 0; ifc.flush = 0;
    ifc.mem_fwd_we = 0; ifc.mem_fwd_rd = 0; ifc.mem_fwd_data = 0;
    ifc.wb_fwd_we = 0; ifc.wb_fwd_rd = 0; ifc.wb_fwd_data = 0;
  endtask

  // Advance one clock; inputs are changed only after the falling edge.
  task automatic step();
    mdl_t nxt = model_next();
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (act_outs() !== '0) begin
      errors++; $display("FAIL reset_initial got=%h want=0", act_outs());
    end
    @(negedge clk); rst = 0;
    ifc.id_valid = 1; ifc.id_pc = 32'h40; ifc.id_rs1_data = 9; ifc.id_rs1 = 2;
    ifc.id_rd = 6; ifc.id_reg_we = 1; ifc.id_mem_we = 1;
    step();
    checks++;
    if (ifc.ex_valid !== 1'b1) begin
      errors++; $display("FAIL reset_preload ex_valid got=%b want=1", ifc.ex_valid);
    end
    drive_idle(); ifc.stall = 1;
    #2 rst = 1;
    #1;
    checks++;
    if (act_outs() !== '0) begin
      errors++; $display("FAIL reset_async got=%h want=0", act_outs());
    end
    m = '0;
    @(negedge clk); rst = 0; ifc.stall = 0;
    $display("test_reset: async clear while stalled checked");
  endtask

  task automatic test_plain_load();
    drive_idle();
    ifc.id_valid = 1; ifc.id_pc = 32'h100; ifc.id_rs1_data = 5; ifc.id_imm = 7;
    ifc.id_src2_sel = 1; ifc.id_alu_op = ALU_ADD; ifc.id_rs1 = 1; ifc.id_rd = 2;
    ifc.id_reg_we = 1;
    step(); drive_idle(); #1;
    checks++;
    if (ifc.alu_src1 !== 32'd5 || ifc.alu_src2 !== 32'd7 || ifc.ex_pc !== 32'h100 ||
        ifc.ex_valid !== 1'b1 || ifc.ex_reg_we !== 1'b1) begin
      errors++;
      $display("FAIL plain_load src1=%h src2=%h pc=%h v=%b rwe=%b want 5 7 100 1 1",
               ifc.alu_src1, ifc.alu_src2, ifc.ex_pc, ifc.ex_valid, ifc.ex_reg_we);
    end
    checks++;
    if (act_outs() !== exp_outs()) begin
      errors++; $display("FAIL plain_load_model got=%h want=%h", act_outs(), exp_outs());
    end
    $display("test_plain_load: pc=%h src1=%h src2=%h", ifc.ex_pc, ifc.alu_src1, ifc.alu_src2);
  endtask

  task automatic test_forward_priority();
    drive_idle();
    ifc.id_valid = 1; ifc.id_rs1 = 3; ifc.id_rs1_data = 32'h11; ifc.id_rs2 = 5;
    ifc.id_rs2_data = 32'h33; ifc.id_alu_op = ALU_SUB; ifc.id_reg_we = 1;
    step(); drive_idle();
    ifc.mem_fwd_we = 1; ifc.mem_fwd_rd = 3; ifc.mem_fwd_data = 32'hAA;
    ifc.wb_fwd_we = 1;  ifc.wb_fwd_rd = 3;  ifc.wb_fwd_data = 32'hBB;
    #1;
    checks++;
    if (ifc.alu_src1 !== 32'hAA) begin
      errors++; $display("FAIL fwd_mem_over_wb got=%h want=aa", ifc.alu_src1);
    end
    ifc.mem_fwd_we = 0; #1;
    checks++;
    if (ifc.alu_src1 !== 32'hBB) begin
      errors++; $display("FAIL fwd_wb got=%h want=bb", ifc.alu_src1);
    end
    ifc.mem_fwd_we = 1; ifc.mem_fwd_rd = 5; ifc.mem_fwd_data = 32'hCC; #1;
    checks++;
    if (ifc.alu_src2 !== 32'hCC || ifc.ex_store_data !== 32'hCC || ifc.alu_src1 !== 32'hBB) begin
      errors++;
      $display("FAIL fwd_rs2 src2=%h store=%h src1=%h want cc cc bb",
               ifc.alu_src2, ifc.ex_store_data, ifc.alu_src1);
    end
    drive_idle();
    ifc.id_valid = 1; ifc.id_rs1 = 0; ifc.id_rs1_data = 32'h22;
    step();
    ifc.mem_fwd_we = 1; ifc.mem_fwd_rd = 0; ifc.mem_fwd_data = 32'hAA;
    ifc.wb_fwd_we = 1;  ifc.wb_fwd_rd = 0;  ifc.wb_fwd_data = 32'hBB;
    #1;
    checks++;
    if (ifc.alu_src1 !== 32'h22) begin
      errors++; $display("FAIL fwd_reg0 got=%h want=22", ifc.alu_src1);
    end
    drive_idle();
    $display("test_forward_priority: mem>wb>reg and x0 never forwarded checked");
  endtask

  task automatic test_stall_refresh();
    drive_idle();
    ifc.id_valid = 1; ifc.id_rs2 = 4; ifc.id_rs2_data = 1; ifc.id_mem_we = 1;
    ifc.id_src2_sel = 1; ifc.id_imm = 32'h99;
    step(); drive_idle();
    ifc.stall = 1; ifc.id_valid = 1; ifc.id_rs2 = 9; ifc.id_rs2_data = 32'h777;
    ifc.wb_fwd_we = 1; ifc.wb_fwd_rd = 4; ifc.wb_fwd_data = 32'h55;
    step();
    ifc.wb_fwd_we = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ifc.ex_store_data !== 32'h55 || ifc.alu_src2 !== 32'h99 || ifc.ex_rs2 !== 5'd4) begin
        errors++;
        $display("FAIL stall_refresh cyc=%0d store=%h src2=%h rs2=%0d want 55 99 4",
                 i, ifc.ex_store_data, ifc.alu_src2, ifc.ex_rs2);
      end
      step();
    end
    drive_idle();
    $display("test_stall_refresh: store_data=%h held across stall", ifc.ex_store_data);
  endtask

  task automatic test_flush_over_stall();
    drive_idle();
    ifc.id_valid = 1; ifc.id_mem_we = 1; ifc.id_reg_we = 1; ifc.id_pc = 32'h300;
    step();
    checks++;
    if (ifc.ex_mem_we !== 1'b1) begin
      errors++; $display("FAIL flush_preload mem_we got=%b want=1", ifc.ex_mem_we);
    end
    ifc.stall = 1; ifc.flush = 1;
    step(); drive_idle(); #1;
    checks++;
    if (ifc.ex_valid !== 1'b0 || ifc.ex_mem_we !== 1'b0 || ifc.ex_reg_we !== 1'b0 ||
        ifc.ex_pc !== 32'h0) begin
      errors++;
      $display("FAIL flush_over_stall v=%b mwe=%b rwe=%b pc=%h want 0 0 0 0",
               ifc.ex_valid, ifc.ex_mem_we, ifc.ex_reg_we, ifc.ex_pc);
    end
    $display("test_flush_over_stall: bubble inserted");
  endtask

  task automatic test_invalid_capture();
    drive_idle();
    ifc.id_valid = 0; ifc.id_reg_we = 1; ifc.id_mem_we = 1; ifc.id_pc = 32'h200;
    step(); drive_idle(); #1;
    checks++;
    if (ifc.ex_reg_we !== 1'b0 || ifc.ex_mem_we !== 1'b0 || ifc.ex_valid !== 1'b0 ||
        ifc.ex_pc !== 32'h200) begin
      errors++;
      $display("FAIL invalid_capture rwe=%b mwe=%b v=%b pc=%h want 0 0 0 200",
               ifc.ex_reg_we, ifc.ex_mem_we, ifc.ex_valid, ifc.ex_pc);
    end
    $display("test_invalid_capture: enables qualified by valid");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ifc.id_valid = 1'($urandom);  ifc.id_pc = $urandom;
      ifc.id_rs1_data = $urandom;   ifc.id_rs2_data = $urandom;
      ifc.id_imm = $urandom;
      ifc.id_rs1 = 5'($urandom_range(0, 7)); ifc.id_rs2 = 5'($urandom_range(0, 7));
      ifc.id_rd = 5'($urandom_range(0, 31)); ifc.id_alu_op = 2'($urandom);
      ifc.id_src1_sel = 1'($urandom); ifc.id_src2_sel = 1'($urandom);
      ifc.id_reg_we = 1'($urandom); ifc.id_mem_we = 1'($urandom);
      ifc.stall = ($urandom_range(0, 3) == 0);
      ifc.flush = ($urandom_range(0, 9) == 0);
      ifc.mem_fwd_we = 1'($urandom); ifc.mem_fwd_rd = 5'($urandom_range(0, 7));
      ifc.mem_fwd_data = $urandom;
      ifc.wb_fwd_we = 1'($urandom);  ifc.wb_fwd_rd = 5'($urandom_range(0, 7));
      ifc.wb_fwd_data = $urandom;
      #1;
      checks++;
      if (act_outs() !== exp_outs()) begin
        errors++; $display("FAIL random n=%0d got=%h want=%h", n, act_outs(), exp_outs());
      end
      $display("random n=%0d stall=%b flush=%b src1=%h src2=%h",
               n, ifc.stall, ifc.flush, ifc.alu_src1, ifc.alu_src2);
      step();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_plain_load();
    test_forward_priority();
    test_stall_refresh();
    test_flush_over_stall();
    test_invalid_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
